pixel_feeder: RTL and testbench

- Transmit side of the CHIP pixel input interface.
- Accepts a raster-order image stream at one 5-bit pixel per cycle through a valid/ready handshake.
- Buffers one 5-row band at a time in ping-pong band buffers.
- Replays each band column by column on the five lanes pixel_in0..pixel_in4, qualified by out_valid, and raises load_end on the final beat of the frame.

---
 rtl/pixel_feeder.sv | 169 ++++++++++++++++
 tb/tb_pixel_feeder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_feeder.sv
// pixel_feeder: transmit side of the CHIP pixel input interface.
// Collects a raster stream into ping-pong band buffers (LANES rows each) and
// replays every completed band column by column on five parallel lanes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset; waiting for start, no input accepted
// RUN   | accepting pixels; completed bands are drained as they fill
// FLUSH | all pixels taken; waiting for the final band drain to end
// DONE  | frame finished; load_end held high until the next start
module pixel_feeder #(
  parameter int PIX_W = 5,
  parameter int IMG_W = 20,
  parameter int IMG_H = 20,
  parameter int LANES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] pixel_in0,
  output logic [PIX_W-1:0] pixel_in1,
  output logic [PIX_W-1:0] pixel_in2,
  output logic [PIX_W-1:0] pixel_in3,
  output logic [PIX_W-1:0] pixel_in4,
  output logic             out_valid,
  output logic             load_end,
  output logic             frame_done
);

  localparam int BUF_D = LANES * IMG_W;
  localparam int BANDS = IMG_H / LANES;
  localparam int AW    = $clog2(2 * BUF_D);
  localparam int IW    = $clog2(BUF_D);
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int BW    = $clog2(BANDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    wr_idx;
  logic [BW-1:0]    wr_band;
  logic             fill_sel;
  logic             drain_sel;
  logic [CW-1:0]    drain_col;
  logic [CW-1:0]    drain_left;
  logic             final_band;
  logic             last_beat_q;
  logic [PIX_W-1:0] lane_q [LANES];
  logic [PIX_W-1:0] mem [2*BUF_D];

  logic             accept, band_done, frame_last, start_ok, last_load;
  logic             rd_sel;
  logic [CW-1:0]    rd_col;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr [LANES];

  // Handshake and band/frame completion decode. Within a band the raster
  // index (row%LANES)*IMG_W + col is simply the running pixel count.
  always_comb begin
    accept     = in_valid && in_ready;
    band_done  = accept && (wr_idx == IW'(BUF_D - 1));
    frame_last = band_done && (wr_band == BW'(BANDS - 1));
    start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    // The first beat of a band is read from the buffer being closed this edge;
    // column 0 of its last row was written long before, so no bypass is needed.
    rd_sel     = band_done ? fill_sel : drain_sel;
    rd_col     = band_done ? '0 : drain_col;
    last_load  = band_done ? (frame_last && (IMG_W == 1))
                           : ((drain_left == CW'(1)) && final_band);
    wr_addr    = (fill_sel ? AW'(BUF_D) : AW'(0)) + AW'(wr_idx);
    for (int r = 0; r < LANES; r++) begin
      rd_addr[r] = (rd_sel ? AW'(BUF_D) : AW'(0)) + AW'(r * IMG_W) + AW'(rd_col);
    end
  end

  // Band buffer storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_pixel;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)       state_d = S_RUN;
      S_RUN:   if (frame_last)  state_d = S_FLUSH;
      S_FLUSH: if (last_beat_q) state_d = S_DONE;
      S_DONE:  if (start)       state_d = S_RUN;
      default:                  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: input is only taken while filling.
  always_comb begin
    in_ready = (state_q == S_RUN);
  end

  // Fill pointers, drain sequencer and registered lane outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx      <= '0;
      wr_band     <= '0;
      fill_sel    <= 1'b0;
      drain_sel   <= 1'b0;
      drain_col   <= '0;
      drain_left  <= '0;
      final_band  <= 1'b0;
      last_beat_q <= 1'b0;
      out_valid   <= 1'b0;
      load_end    <= 1'b0;
      frame_done  <= 1'b0;
      for (int r = 0; r < LANES; r++) lane_q[r] <= '0;
    end else begin
      last_beat_q <= last_load;
      frame_done  <= last_beat_q;

      if (start_ok) begin
        wr_idx   <= '0;
        wr_band  <= '0;
        fill_sel <= 1'b0;
        load_end <= 1'b0;
      end else if (accept) begin
        if (band_done) begin
          wr_idx   <= '0;
          fill_sel <= ~fill_sel;
          wr_band  <= frame_last ? '0 : wr_band + BW'(1);
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end

      if (last_load) load_end <= 1'b1;

      // drain_left counts beats still owed after the one being loaded now
      if (band_done) begin
        drain_sel  <= fill_sel;
        drain_col  <= CW'(1);
        drain_left <= CW'(IMG_W - 1);
        final_band <= frame_last;
        out_valid  <= 1'b1;
        for (int r = 0; r < LANES; r++) lane_q[r] <= mem[rd_addr[r]];
      end else if (drain_left != '0) begin
        drain_col  <= drain_col + CW'(1);
        drain_left <= drain_left - CW'(1);
        out_valid  <= 1'b1;
        for (int r = 0; r < LANES; r++) lane_q[r] <= mem[rd_addr[r]];
      end else begin
        out_valid <= 1'b0;
        for (int r = 0; r < LANES; r++) lane_q[r] <= '0;
      end
    end
  end

  assign pixel_in0 = lane_q[0];
  assign pixel_in1 = lane_q[1];
  assign pixel_in2 = lane_q[2];
  assign pixel_in3 = lane_q[3];
  assign pixel_in4 = lane_q[4];

endmodule

// File: tb/tb_pixel_feeder.sv
// Bench for pixel_feeder: randomized-gap frames compared against an image
// model, a table of hand-derived beats, and reset / start corner sequences.
module tb_pixel_feeder;
  localparam int W = 20, H = 20, L = 5, NB = 80, NPIX = 400;

  logic       clk = 0, reset = 0, start = 0, in_valid = 0;
  logic [4:0] in_pixel = 0;
  logic       in_ready, out_valid, load_end, frame_done;
  logic [4:0] pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
  logic [24:0] lanes_w;

  pixel_feeder dut (
    .clk(clk), .reset(reset), .start(start), .in_pixel(in_pixel),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel_in0(pixel_in0), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
    .pixel_in3(pixel_in3), .pixel_in4(pixel_in4),
    .out_valid(out_valid), .load_end(load_end), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  assign lanes_w = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Image content by pattern: 0 -> (row+col)%32, 1 -> (31-row)%32
  function automatic int pix(input int pat, input int row, input int col);
    if (pat == 0) return (row + col) % 32;
    return (31 - row) % 32;
  endfunction

  // Beat k shows column k%W of band k/W, lane r = row band*L + r
  function automatic int model_beat(input int pat, input int k);
    int v = 0;
    for (int r = 0; r < L; r++) v |= pix(pat, (k / W) * L + r, k % W) << (5 * r);
    return v;
  endfunction

  typedef struct { int pat; int beat; int l0, l1, l2, l3, l4; } vec_t;
  vec_t vecs[10];

  // Output monitor, sampled on the falling edge
  logic [24:0] beat_q[$];
  int beat_cyc[$];
  int cyc = 0, le_rises = 0, le_cyc = -1, fd_cnt = 0, fd_cyc = -1, zero_viol = 0;
  logic le_prev = 0;
  int acc_cyc[NPIX];

  always @(negedge clk) begin
    cyc++;
    if (out_valid) begin
      beat_q.push_back(lanes_w);
      beat_cyc.push_back(cyc);
    end else if (lanes_w != 0) zero_viol++;
    if (load_end && !le_prev) begin le_rises++; le_cyc = cyc; end
    le_prev = load_end;
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    beat_q.delete(); beat_cyc.delete();
    le_rises = 0; le_cyc = -1; fd_cnt = 0; fd_cyc = -1; zero_viol = 0;
    le_prev = load_end;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  // Feed one raster frame; gap = percent of cycles with in_valid low
  task automatic feed(input int pat, input int gap, input bit spam, input int abort_at);
    int idx = 0, it = 0;
    bit v, rdy;
    while (idx < NPIX && it < 20000) begin
      if (abort_at >= 0 && idx == abort_at) return;
      @(negedge clk);
      v = ($urandom_range(99) >= gap);
      in_valid = v;
      in_pixel = 5'(pix(pat, idx / W, idx % W));
      start = spam && (it == 150);
      rdy = in_ready;
      @(posedge clk);
      if (v && rdy) begin acc_cyc[idx] = cyc; idx++; end
      it++;
    end
    @(negedge clk);
    in_valid = 0; start = 0;
    chk("feed_complete", idx, NPIX);
    chk("in_ready_after_last", int'(in_ready), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (fd_cnt == 0 && n < 300) begin @(negedge clk); n++; end
    chk("frame_done_seen", int'(fd_cnt > 0), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input int pat, input string tag);
    int bad, bursts, e;
    chk({tag, "_beat_count"}, beat_q.size(), NB);
    if (beat_q.size() == NB) begin
      for (int k = 0; k < NB; k++)
        chk($sformatf("%s_beat%0d", tag, k), int'(beat_q[k]), model_beat(pat, k));
      foreach (vecs[i]) if (vecs[i].pat == pat) begin
        e = vecs[i].l0 | (vecs[i].l1 << 5) | (vecs[i].l2 << 10) | (vecs[i].l3 << 15) | (vecs[i].l4 << 20);
        chk($sformatf("%s_vec_beat%0d", tag, vecs[i].beat), int'(beat_q[vecs[i].beat]), e);
      end
      bad = 0; bursts = 0;
      for (int k = 0; k < NB; k++) begin
        if (k == 0 || beat_cyc[k] != beat_cyc[k-1] + 1) bursts++;
        if (k % W != 0 && beat_cyc[k] != beat_cyc[k-1] + 1) bad++;
      end
      chk({tag, "_burst_gaps"}, bad, 0);
      chk({tag, "_burst_count"}, bursts, 4);
      for (int b = 0; b < 4; b++)
        chk($sformatf("%s_latency_band%0d", tag, b), beat_cyc[b*W], acc_cyc[(b+1)*L*W - 1] + 1);
      chk({tag, "_load_end_cycle"}, le_cyc, beat_cyc[NB-1]);
      chk({tag, "_frame_done_cycle"}, fd_cyc, beat_cyc[NB-1] + 1);
    end
    chk({tag, "_load_end_rises"}, le_rises, 1);
    chk({tag, "_frame_done_pulses"}, fd_cnt, 1);
    chk({tag, "_idle_lanes_zero"}, zero_viol, 0);
  endtask

  initial begin
    vecs[0] = '{0,  0,  0,  1,  2,  3,  4};
    vecs[1] = '{0, 19, 19, 20, 21, 22, 23};
    vecs[2] = '{0, 20,  5,  6,  7,  8,  9};
    vecs[3] = '{0, 45, 15, 16, 17, 18, 19};
    vecs[4] = '{0, 72, 27, 28, 29, 30, 31};
    vecs[5] = '{0, 73, 28, 29, 30, 31,  0};
    vecs[6] = '{0, 79,  2,  3,  4,  5,  6};
    vecs[7] = '{1,  0, 31, 30, 29, 28, 27};
    vecs[8] = '{1, 40, 21, 20, 19, 18, 17};
    vecs[9] = '{1, 79, 16, 15, 14, 13, 12};

    // Reset state
    #23;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_lanes", int'(lanes_w), 0);
    chk("rst_load_end", int'(load_end), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    @(negedge clk) reset = 1;
    repeat (5) @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 0);

    // Frame A: no gaps, start pulsed in RUN and in FLUSH
    clear_mon();
    pulse_start();
    feed(0, 0, 1, -1);
    chk("A_flush_draining", int'(out_valid), 1);
    pulse_start();
    wait_done();
    check_frame(0, "A");

    // Frame B: back-to-back from DONE, second image, random gaps
    chk("B_load_end_held", int'(load_end), 1);
    clear_mon();
    pulse_start();
    chk("B_load_end_cleared", int'(load_end), 0);
    feed(1, 50, 0, -1);
    wait_done();
    check_frame(1, "B");

    // Frame C: first image with random gaps
    clear_mon();
    pulse_start();
    feed(0, 50, 0, -1);
    wait_done();
    check_frame(0, "C");

    // Frame D: reset while band 1 drains and band 2 fills
    clear_mon();
    pulse_start();
    feed(0, 0, 0, 210);
    #1;
    chk("D_pre_reset_drain", int'(out_valid), 1);
    #2 reset = 0;
    in_valid = 0;
    #1;
    chk("D_rst_out_valid", int'(out_valid), 0);
    chk("D_rst_lanes", int'(lanes_w), 0);
    chk("D_rst_in_ready", int'(in_ready), 0);
    chk("D_rst_load_end", int'(load_end), 0);
    chk("D_rst_frame_done", int'(frame_done), 0);
    repeat (2) @(negedge clk);
    reset = 1;
    clear_mon();
    repeat (40) @(negedge clk);
    chk("D_no_beats_before_start", beat_q.size(), 0);
    chk("D_idle_in_ready", int'(in_ready), 0);

    // Frame E: full frame after the aborted one
    clear_mon();
    pulse_start();
    feed(0, 30, 0, -1);
    wait_done();
    check_frame(0, "E");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
